vram_port_arbiter: RTL and testbench

- Shares one port of the 96x8 dual-port VRAM between two requesters: A = display fetch (read-only, deadline-critical) and B = game-logic read/write (Nios-side tile/score updates).
- Contains a clear engine that fills all 96 bytes with a constant value on command.
- Sits between the requesters and the VRAM Avalon-style slave port (address / chipselect / write / writedata / readdata).

---
 rtl/vram_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_vram_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// Two-requester arbiter (display fetch A, game logic B) plus clear engine for one VRAM port.
// Optional conflict statistics counter is built when VRAM_ARB_STATS_EN is defined.
module vram_port_arbiter #(
  parameter int unsigned       ADDR_W     = 7,
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       DEPTH      = 96,
  parameter int unsigned       B_MAX_WAIT = 4,
  parameter logic [DATA_W-1:0] CLR_VALUE  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic [15:0]       stat_conflicts
);

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        B_MAX     = 4'(B_MAX_WAIT);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [3:0]        b_wait_q, b_wait_d;
  logic              a_rvalid_q, b_rvalid_q;
  logic              a_oor_q, b_oor_q;
  logic              clr_done_q, clr_done_d;
  logic              a_in_range, b_in_range, b_force, clr_last;

  assign a_in_range = {1'b0, a_addr} < DEPTH_L;
  assign b_in_range = {1'b0, b_addr} < DEPTH_L;
  assign b_force    = b_wait_q >= B_MAX;
  assign clr_last   = clr_addr_q == LAST_ADDR;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (clr_start) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_last)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Grants and port muxing; reset_n gates the grants so nothing leaks out during reset.
  always_comb begin
    a_gnt          = 1'b0;
    b_gnt          = 1'b0;
    ram_address    = a_addr;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_writedata  = b_wdata;
    clr_busy       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (reset_n) begin
          b_gnt = b_req & (b_force | ~a_req);
          a_gnt = a_req & ~b_gnt;
          if (b_gnt) ram_address = b_addr;
          ram_chipselect = (a_gnt & a_in_range) | (b_gnt & b_in_range);
          ram_write      = b_gnt & b_we & b_in_range;
        end
      end
      ST_CLEAR: begin
        ram_address    = clr_addr_q;
        ram_chipselect = 1'b1;
        ram_write      = 1'b1;
        ram_writedata  = CLR_VALUE;
        clr_busy       = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    clr_addr_d = (state_q == ST_CLEAR) ? clr_addr_q + 1'b1 : '0;
    clr_done_d = (state_q == ST_CLEAR) && clr_last;
    b_wait_d   = b_wait_q;
    if (b_gnt)
      b_wait_d = '0;
    else if ((state_q == ST_IDLE) && b_req && (b_wait_q != 4'hF))
      b_wait_d = b_wait_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_addr_q <= '0;
      clr_done_q <= 1'b0;
      b_wait_q   <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_oor_q    <= 1'b0;
      b_oor_q    <= 1'b0;
    end else begin
      clr_addr_q <= clr_addr_d;
      clr_done_q <= clr_done_d;
      b_wait_q   <= b_wait_d;
      a_rvalid_q <= a_gnt;
      b_rvalid_q <= b_gnt & ~b_we;
      a_oor_q    <= ~a_in_range;
      b_oor_q    <= ~b_in_range;
    end
  end

  // Out-of-range reads never touched the RAM, so their data is forced to zero.
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = (a_rvalid_q && !a_oor_q) ? ram_readdata : '0;
  assign b_rdata  = (b_rvalid_q && !b_oor_q) ? ram_readdata : '0;
  assign clr_done = clr_done_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stat_q <= '0;
    else if ((state_q == ST_IDLE) && clr_start)
      stat_q <= '0;
    else if ((state_q == ST_IDLE) && a_req && b_req && (stat_q != 16'hFFFF))
      stat_q <= stat_q + 16'd1;
  end

  assign stat_conflicts = stat_q;
`else
  assign stat_conflicts = 16'h0000;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Randomized bench for vram_port_arbiter against a transaction-level model of the shared port,
// with a behavioural 96x8 VRAM attached to the slave side.
module tb_vram_port_arbiter;

  localparam int        DEPTH      = 96;
  localparam int        B_MAX_WAIT = 4;
  localparam logic [7:0] CLR       = 8'h00;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_req, b_req, b_we, clr_start;
  logic [6:0] a_addr, b_addr;
  logic [7:0] b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, clr_busy, clr_done;
  logic [7:0] a_rdata, b_rdata;
  logic [6:0] ram_address;
  logic       ram_chipselect, ram_write;
  logic [7:0] ram_writedata, ram_readdata;
  logic [15:0] stat_conflicts;

  always #5 clk = ~clk;

  vram_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata),
    .stat_conflicts(stat_conflicts)
  );

  // Behavioural VRAM slave: synchronous write, one-cycle read latency.
  logic [7:0] vmem [DEPTH];
  always @(posedge clk) begin
    if (ram_chipselect && (int'(ram_address) < DEPTH)) begin
      if (ram_write) vmem[ram_address] <= ram_writedata;
      else           ram_readdata      <= vmem[ram_address];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what the port should do, tracked as plain counters and a memory image.
  logic [7:0] ref_mem [DEPTH];
  bit         m_clear, m_arv, m_brv, m_done, g_a, g_b;
  int         m_idx, m_bwait, m_stat;
  logic [7:0] m_ard, m_brd;
  logic       smp_ag, smp_bg, smp_cs, smp_busy, smp_done;
  logic [7:0] smp_ard;

  function automatic int exp_stat();
`ifdef VRAM_ARB_STATS_EN
    return m_stat;
`else
    return 0;
`endif
  endfunction

  task automatic reset_model();
    m_clear = 0; m_idx = 0; m_bwait = 0; m_stat = 0;
    m_arv = 0; m_brv = 0; m_done = 0; g_a = 0; g_b = 0;
  endtask

  function automatic logic [7:0] mem_rd(input logic [6:0] addr);
    return (int'(addr) < DEPTH) ? ref_mem[addr] : 8'h00;
  endfunction

  // One clock: check DUT at the negedge against the model, then advance the model at the posedge.
  task automatic cycle();
    bit ea, eb, ecs, ewr;
    logic [6:0] eaddr;
    @(negedge clk);
    if (m_clear) begin
      ea = 0; eb = 0; ecs = 1; ewr = 1; eaddr = 7'(m_idx);
    end else begin
      eb    = b_req && ((m_bwait >= B_MAX_WAIT) || !a_req);
      ea    = a_req && !eb;
      eaddr = eb ? b_addr : a_addr;
      ecs   = (ea || eb) && (int'(eaddr) < DEPTH);
      ewr   = ecs && eb && b_we;
    end
    smp_ag = a_gnt; smp_bg = b_gnt; smp_cs = ram_chipselect;
    smp_busy = clr_busy; smp_done = clr_done; smp_ard = a_rdata;
    check("a_gnt", a_gnt, ea);
    check("b_gnt", b_gnt, eb);
    check("ram_chipselect", ram_chipselect, ecs);
    check("ram_write", ram_write, ewr);
    if (ecs) check("ram_address", ram_address, eaddr);
    if (ewr) check("ram_writedata", ram_writedata, m_clear ? CLR : b_wdata);
    check("a_rvalid", a_rvalid, m_arv);
    check("a_rdata", a_rdata, m_arv ? m_ard : 8'h00);
    check("b_rvalid", b_rvalid, m_brv);
    check("b_rdata", b_rdata, m_brv ? m_brd : 8'h00);
    check("clr_busy", clr_busy, m_clear);
    check("clr_done", clr_done, m_done);
    check("stat_conflicts", stat_conflicts, exp_stat());
    @(posedge clk);
    m_arv = ea;          m_ard = mem_rd(a_addr);
    m_brv = eb && !b_we; m_brd = mem_rd(b_addr);
    if (ewr && !m_clear) ref_mem[b_addr] = b_wdata;
    m_done = 0;
    if (m_clear) begin
      ref_mem[m_idx] = CLR;
      if (m_idx == DEPTH - 1) begin m_clear = 0; m_done = 1; end
      else m_idx++;
    end else begin
      if (eb) m_bwait = 0;
      else if (b_req && m_bwait < 15) m_bwait++;
      if (clr_start) m_stat = 0;
      else if (a_req && b_req && m_stat < 65535) m_stat++;
      if (clr_start) begin m_clear = 1; m_idx = 0; end
    end
    g_a = ea; g_b = eb;
    #1;
  endtask

  task automatic b_write(input logic [6:0] addr, input logic [7:0] data);
    int guard = 0;
    b_req = 1; b_we = 1; b_addr = addr; b_wdata = data;
    do begin cycle(); guard++; end while (!g_b && guard < 200);
    check("b_write_gnt", smp_bg, 1'b1);
    b_req = 0;
  endtask

  task automatic a_read(input logic [6:0] addr, output logic [7:0] data);
    int guard = 0;
    a_req = 1; a_addr = addr;
    do begin cycle(); guard++; end while (!g_a && guard < 200);
    check("a_read_gnt", smp_ag, 1'b1);
    a_req = 0;
    cycle();
    data = smp_ard;
  endtask

  function automatic logic [6:0] pick_addr();
    return ($urandom_range(0, 15) == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 95));
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_gnt"}, a_gnt, 0);
    check({tag, "_b_gnt"}, b_gnt, 0);
    check({tag, "_cs"}, ram_chipselect, 0);
    check({tag, "_we"}, ram_write, 0);
    check({tag, "_a_rvalid"}, a_rvalid, 0);
    check({tag, "_b_rvalid"}, b_rvalid, 0);
    check({tag, "_a_rdata"}, a_rdata, 0);
    check({tag, "_b_rdata"}, b_rdata, 0);
    check({tag, "_busy"}, clr_busy, 0);
    check({tag, "_done"}, clr_done, 0);
    check({tag, "_stat"}, stat_conflicts, 0);
  endtask

  initial begin
    logic [7:0] d;
    int bcyc, busy_cnt, gnt_in_busy, done_cnt;
    logic done_gnt;

    reset_n = 0; clr_start = 0;
    a_req = 1; a_addr = 0; b_req = 1; b_we = 1; b_addr = 0; b_wdata = 0;
    #12;
    check_reset_outputs("por");
    a_req = 0; b_req = 0;
    #10 reset_n = 1;
    reset_model();
    repeat (3) cycle();

    for (int i = 0; i < DEPTH; i++) b_write(7'(i), (i == 5) ? 8'hA5 : 8'($urandom));

    a_req = 1; a_addr = 7'd5;
    cycle();
    check("single_gnt", smp_ag, 1'b1);
    a_req = 0;
    cycle();
    check("single_rdata", smp_ard, 8'hA5);

    a_req = 1; a_addr = 7'd20;
    b_req = 1; b_we = 1; b_addr = 7'd10; b_wdata = 8'h3C;
    bcyc = -1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (smp_bg) begin bcyc = k; break; end
    end
    a_req = 0; b_req = 0;
    check("starve_b_cycle", 32'(bcyc), 32'd4);
    cycle();
    a_read(7'd10, d);
    check("starve_readback", d, 8'h3C);

    b_req = 1; b_we = 1; b_addr = 7'd100; b_wdata = 8'h77;
    cycle();
    check("oor_b_gnt", smp_bg, 1'b1);
    check("oor_cs", smp_cs, 1'b0);
    b_req = 0;
    a_read(7'd100, d);
    check("oor_rdata", d, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      a_read(7'(i), d);
      check("oor_unchanged", d, ref_mem[i]);
    end

    for (int i = 0; i < DEPTH; i++) b_write(7'(i), 8'hFF);
    a_req = 1; a_addr = 7'd3; clr_start = 1;
    cycle();
    clr_start = 0;
    busy_cnt = 0; gnt_in_busy = 0; done_cnt = 0; done_gnt = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (smp_busy) busy_cnt++;
      if (smp_busy && smp_ag) gnt_in_busy++;
      if (smp_done) begin done_cnt++; done_gnt = smp_ag; break; end
    end
    check("clr_busy_cycles", 32'(busy_cnt), 32'd96);
    check("clr_gnt_in_busy", 32'(gnt_in_busy), 32'd0);
    check("clr_done_seen", 32'(done_cnt), 32'd1);
    check("clr_done_gnt", done_gnt, 1'b1);
    cycle();
    check("clr_done_once", smp_done, 1'b0);
    a_req = 0;
    cycle();
    for (int i = 0; i < DEPTH; i++) begin
      a_read(7'(i), d);
      check("clr_readback", d, CLR);
    end

    a_req = 1; a_addr = 7'd0; b_req = 1; b_we = 0; b_addr = 7'd1;
    repeat (10) cycle();
`ifdef VRAM_ARB_STATS_EN
    check("stat_10", stat_conflicts, 16'd10);
`else
    check("stat_10", stat_conflicts, 16'd0);
`endif
    a_req = 0; b_req = 0; clr_start = 1;
    cycle();
    clr_start = 0;
    check("stat_cleared", stat_conflicts, 16'd0);
    repeat (100) cycle();

    for (int n = 0; n < 3000; n++) begin
      if (!a_req || g_a) begin a_req = 1'($urandom_range(0, 1)); a_addr = pick_addr(); end
      if (!b_req || g_b) begin
        b_req = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
        b_addr = pick_addr(); b_wdata = 8'($urandom);
      end
      clr_start = !m_clear && ($urandom_range(0, 299) == 0);
      if (n == 1500) begin
        a_req = 1; b_req = 1; clr_start = 0;
        #2 reset_n = 0;
        #1 check_reset_outputs("mid_rst");
        @(posedge clk);
        #3 reset_n = 1;
        reset_model();
        a_req = 0; b_req = 0;
        repeat (3) cycle();
      end else begin
        cycle();
      end
    end
    clr_start = 0; a_req = 0; b_req = 0;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
